// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One bit per cycle (shift-add multiply, restoring divide), with fast paths for divide-by-zero and signed overflow.
module ex_mdu #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_i_flush,
  input  logic            mdu_i_valid,
  input  logic [2:0]      mdu_i_funct3,
  input  logic [XLEN-1:0] mdu_i_a,
  input  logic [XLEN-1:0] mdu_i_b,
  input  logic [4:0]      mdu_i_rd,
  output logic            mdu_o_ready,
  output logic            mdu_o_stall,
  output logic            mdu_o_valid,
  output logic [XLEN-1:0] mdu_o_result,
  output logic [4:0]      mdu_o_rd
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0]   L_ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] L_ONE2     = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   L_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]     L_CNT_INIT = CW'(XLEN-1);
  localparam logic [CW-1:0]     L_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_opd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_hi;
  logic                r_rem;

  logic                w_accept;
  logic                w_is_div;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_fast_res;
  logic [XLEN:0]       w_sum;
  logic [XLEN:0]       w_mul_hi;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN-1:0]     w_div_raw;
  logic [XLEN-1:0]     w_div_res;

  // Accept decode: operand signedness, magnitudes and fast-path detection
  always_comb begin
    w_accept = mdu_i_valid && (r_state == S_IDLE) && !mdu_i_flush;
    w_is_div = mdu_i_funct3[2];
    if (w_is_div) begin
      w_sgn_a = !mdu_i_funct3[0];
      w_sgn_b = !mdu_i_funct3[0];
    end else begin
      w_sgn_a = (mdu_i_funct3[1:0] == 2'b01) || (mdu_i_funct3[1:0] == 2'b10);
      w_sgn_b = (mdu_i_funct3[1:0] == 2'b01);
    end
    w_neg_a = w_sgn_a && mdu_i_a[XLEN-1];
    w_neg_b = w_sgn_b && mdu_i_b[XLEN-1];
    if (w_neg_a) begin
      w_abs_a = ~mdu_i_a + L_ONE;
    end else begin
      w_abs_a = mdu_i_a;
    end
    if (w_neg_b) begin
      w_abs_b = ~mdu_i_b + L_ONE;
    end else begin
      w_abs_b = mdu_i_b;
    end
    w_div0 = w_is_div && (mdu_i_b == '0);
    w_ovf  = w_is_div && !mdu_i_funct3[0] && (mdu_i_a == L_MIN) && (mdu_i_b == '1);
    // funct3[1] selects the remainder flavour of the divide ops
    if (w_div0) begin
      w_fast_res = mdu_i_funct3[1] ? mdu_i_a : '1;
    end else if (w_ovf) begin
      w_fast_res = mdu_i_funct3[1] ? '0 : mdu_i_a;
    end else begin
      w_fast_res = '0;
    end
  end

  // Iteration step datapath and final sign correction
  always_comb begin
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opd};
    if (r_acc[0]) begin
      w_mul_hi = w_sum;
    end else begin
      w_mul_hi = {1'b0, r_acc[2*XLEN-1:XLEN]};
    end
    w_mul_nxt = {w_mul_hi, r_acc[XLEN-1:1]};

    // acc holds {partial remainder, remaining dividend / quotient bits}
    w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opd};
    if (w_diff[XLEN]) begin
      w_div_nxt = {r_acc[2*XLEN-2:0], 1'b0};
    end else begin
      w_div_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    if (r_neg) begin
      w_prod = ~w_mul_nxt + L_ONE2;
    end else begin
      w_prod = w_mul_nxt;
    end
    if (r_hi) begin
      w_mul_res = w_prod[2*XLEN-1:XLEN];
    end else begin
      w_mul_res = w_prod[XLEN-1:0];
    end

    if (r_rem) begin
      w_div_raw = w_div_nxt[2*XLEN-1:XLEN];
    end else begin
      w_div_raw = w_div_nxt[XLEN-1:0];
    end
    if (r_neg) begin
      w_div_res = ~w_div_raw + L_ONE;
    end else begin
      w_div_res = w_div_raw;
    end
  end

  // Control FSM with operand, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_opd        <= '0;
      r_acc        <= '0;
      r_neg        <= 1'b0;
      r_hi         <= 1'b0;
      r_rem        <= 1'b0;
      mdu_o_result <= '0;
      mdu_o_rd     <= 5'd0;
    end else if (mdu_i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= L_CNT_INIT;
            mdu_o_rd <= mdu_i_rd;
            r_hi     <= (mdu_i_funct3[1:0] != 2'b00);
            r_rem    <= mdu_i_funct3[1];
            r_neg    <= (w_is_div && mdu_i_funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
            if (w_div0 || w_ovf) begin
              mdu_o_result <= w_fast_res;
              r_state      <= S_DONE;
            end else if (w_is_div) begin
              r_opd   <= w_abs_b;
              r_acc   <= {{XLEN{1'b0}}, w_abs_a};
              r_state <= S_DIV;
            end else begin
              r_opd   <= w_abs_a;
              r_acc   <= {{XLEN{1'b0}}, w_abs_b};
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          if (r_cnt == '0) begin
            mdu_o_result <= w_mul_res;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - L_CNT_ONE;
          end
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          if (r_cnt == '0) begin
            mdu_o_result <= w_div_res;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - L_CNT_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    mdu_o_ready = (r_state == S_IDLE);
    mdu_o_valid = (r_state == S_DONE) && !mdu_i_flush;
    mdu_o_stall = ((r_state == S_MUL) || (r_state == S_DIV) ||
                   ((r_state == S_IDLE) && mdu_i_valid)) && !mdu_i_flush;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: a 32-bit and a 16-bit instance driven from one linear sequence.
module tb_ex_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s;
  logic        v32, v16;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic        rdy32, stl32, val32, rdy16, stl16, val16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic [4:0]  ord32, ord16;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .mdu_i_flush(flush), .mdu_i_valid(v32), .mdu_i_funct3(f3_s),
    .mdu_i_a(a32), .mdu_i_b(b32), .mdu_i_rd(rd_s), .mdu_o_ready(rdy32), .mdu_o_stall(stl32),
    .mdu_o_valid(val32), .mdu_o_result(res32), .mdu_o_rd(ord32)
  );

  ex_mdu #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .mdu_i_flush(flush), .mdu_i_valid(v16), .mdu_i_funct3(f3_s),
    .mdu_i_a(a16), .mdu_i_b(b16), .mdu_i_rd(rd_s), .mdu_o_ready(rdy16), .mdu_o_stall(stl16),
    .mdu_o_valid(val16), .mdu_o_result(res16), .mdu_o_rd(ord16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the unit idle; presents the op in that cycle (cycle 0).
  task automatic run_op(input bit w16, input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rdv,
                        input logic [31:0] exp, input int lat, input bit busy_req);
    int seen;
    bit stall_ok;
    logic o_v, o_s;
    f3_s = f3;
    rd_s = rdv;
    if (w16) begin
      a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1;
    end else begin
      a32 = a; b32 = b; v32 = 1'b1;
    end
    #1;
    check({tag, " ready@0"}, {31'd0, (w16 ? rdy16 : rdy32)}, 32'd1);
    check({tag, " stall@0"}, {31'd0, (w16 ? stl16 : stl32)}, 32'd1);
    seen = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 60 && seen < 0; c++) begin
      @(negedge clk);
      v16 = 1'b0;
      v32 = busy_req && !w16;
      if (busy_req) begin
        a32 = 32'd1; b32 = 32'd1; f3_s = 3'b000; rd_s = 5'd31;
      end
      #1;
      o_v = w16 ? val16 : val32;
      o_s = w16 ? stl16 : stl32;
      if (o_v) begin
        seen = c;
        if (o_s) stall_ok = 1'b0;
      end else if (!o_s) begin
        stall_ok = 1'b0;
      end
    end
    check({tag, " latency"}, 32'(seen), 32'(lat));
    check({tag, " result"}, w16 ? {16'd0, res16} : res32, exp);
    check({tag, " rd"}, {27'd0, (w16 ? ord16 : ord32)}, {27'd0, rdv});
    check({tag, " stall_profile"}, {31'd0, stall_ok}, 32'd1);
    @(negedge clk);
    v32 = 1'b0;
    v16 = 1'b0;
    #1;
    check({tag, " valid_after"}, {31'd0, (w16 ? val16 : val32)}, 32'd0);
    check({tag, " ready_after"}, {31'd0, (w16 ? rdy16 : rdy32)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; v32 = 1'b1; v16 = 1'b1;
    f3_s = 3'b000; rd_s = 5'd7; a32 = 32'd3; b32 = 32'd3; a16 = 16'd3; b16 = 16'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0; v32 = 1'b0; v16 = 1'b0;
    #1;
    check("reset ready", {31'd0, rdy32}, 32'd1);
    check("reset valid", {31'd0, val32}, 32'd0);
    check("reset result", res32, 32'd0);
    check("reset rd", {27'd0, ord32}, 32'd0);
    check("reset stall", {31'd0, stl32}, 32'd0);

    @(negedge clk);
    run_op(1'b0, "MUL",       3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b1);
    run_op(1'b0, "MULH",      3'b001, 32'd7,         32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFFF, 33, 1'b0);
    run_op(1'b0, "MULHU",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, 1'b0);
    run_op(1'b0, "MULHSU",    3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b0);
    run_op(1'b0, "MULneg",    3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd9,  32'd6,         33, 1'b0);
    run_op(1'b0, "DIV",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33, 1'b0);
    run_op(1'b0, "REM",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33, 1'b0);
    run_op(1'b0, "DIVU",      3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        33, 1'b0);
    run_op(1'b0, "REMU",      3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         33, 1'b0);
    run_op(1'b0, "DIVU_by0",  3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1,  1'b0);
    run_op(1'b0, "REM_by0",   3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         1,  1'b0);
    run_op(1'b0, "DIV_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1,  1'b0);
    run_op(1'b0, "REM_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1,  1'b0);

    // Flush in cycle 10 of a multiply, then a fresh multiply from cycle 11
    f3_s = 3'b000; a32 = 32'd5; b32 = 32'd6; rd_s = 5'd20; v32 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      v32 = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush valid@10", {31'd0, val32}, 32'd0);
    check("flush stall@10", {31'd0, stl32}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush ready@11", {31'd0, rdy32}, 32'd1);
    check("flush valid@11", {31'd0, val32}, 32'd0);
    run_op(1'b0, "MUL_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, 1'b0);

    // Flush coinciding with a request blocks the accept
    f3_s = 3'b101; a32 = 32'd9; b32 = 32'd3; rd_s = 5'd22; v32 = 1'b1; flush = 1'b1;
    #1;
    check("flush_req stall", {31'd0, stl32}, 32'd0);
    @(negedge clk);
    v32 = 1'b0; flush = 1'b0;
    #1;
    check("flush_req ready", {31'd0, rdy32}, 32'd1);
    check("flush_req rd", {27'd0, ord32}, 32'd21);

    run_op(1'b1, "MULHU16", 3'b011, 32'h0000_FFFF, 32'h0000_FFFF, 5'd3, 32'h0000_FFFE, 17, 1'b0);
    run_op(1'b1, "DIVU16",  3'b101, 32'h0000_FFFF, 32'h0000_0010, 5'd4, 32'h0000_0FFF, 17, 1'b0);

    // Reset in the middle of a divide aborts it and clears the result
    f3_s = 3'b101; a32 = 32'd50; b32 = 32'd5; rd_s = 5'd25; v32 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      v32 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset ready", {31'd0, rdy32}, 32'd1);
    check("midreset result", res32, 32'd0);
    check("midreset rd", {27'd0, ord32}, 32'd0);
    check("midreset stall", {31'd0, stl32}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      #1;
      check("midreset no_valid", {31'd0, val32}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
